// File: rtl/uinst_sequencer.sv
// rtl/uinst_sequencer.sv - microcode sequencer: fetches ROM words, issues EXEC words over valid/ready
// and consumes JUMP, single-level LOOP and HALT locally.
module uinst_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  output logic                  uinst_valid,
  output logic [DATA_WIDTH-1:0] uinst_data,
  input  logic                  uinst_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, FETCH, DECODE, ISSUE} state_t;

  localparam logic [1:0] OP_EXEC = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_LOOP = 2'b10;
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pc;
  logic                    loop_active;
  logic [7:0]              loop_cnt;
  logic [1:0]              op;
  logic [ADDR_WIDTH-1:0]   tgt;
  logic [7:0]              cnt;

  assign op       = rom_dout[DATA_WIDTH-1 -: 2];
  assign tgt      = rom_dout[DATA_WIDTH-3 -: ADDR_WIDTH];
  assign cnt      = rom_dout[7:0];
  assign rom_addr = pc;

  // rom_en is raised on every transition into FETCH so the ROM read lines up with DECODE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      pc          <= '0;
      loop_active <= 1'b0;
      loop_cnt    <= '0;
      rom_en      <= 1'b0;
      uinst_valid <= 1'b0;
      uinst_data  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      rom_en <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pc          <= start_addr;
            loop_active <= 1'b0;
            rom_en      <= 1'b1;
            busy        <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          state  <= FETCH;
          rom_en <= 1'b1;
          case (op)
            OP_EXEC: begin
              uinst_data  <= rom_dout;
              uinst_valid <= 1'b1;
              rom_en      <= 1'b0;
              state       <= ISSUE;
            end
            OP_JUMP: pc <= tgt;
            OP_LOOP: begin
              // loop_cnt holds the repeats still owed after the current pass.
              if (!loop_active) begin
                if (cnt == 8'd0) begin
                  pc <= pc + PC_ONE;
                end else begin
                  loop_active <= 1'b1;
                  loop_cnt    <= cnt - 8'd1;
                  pc          <= tgt;
                end
              end else if (loop_cnt == 8'd0) begin
                loop_active <= 1'b0;
                pc          <= pc + PC_ONE;
              end else begin
                loop_cnt <= loop_cnt - 8'd1;
                pc       <= tgt;
              end
            end
            default: begin
              done   <= 1'b1;
              busy   <= 1'b0;
              rom_en <= 1'b0;
              state  <= IDLE;
            end
          endcase
        end
        ISSUE: begin
          if (uinst_ready) begin
            uinst_valid <= 1'b0;
            pc          <= pc + PC_ONE;
            rom_en      <= 1'b1;
            state       <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uinst_sequencer.sv
// tb/tb_uinst_sequencer.sv - randomized self-checking bench for uinst_sequencer against a
// program-level reference model.
module tb_uinst_sequencer;

  localparam int AW = 12;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout = '0;
  logic          uinst_valid;
  logic [DW-1:0] uinst_data;
  logic          uinst_ready = 1'b1;
  logic          busy;
  logic          done;

  uinst_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .start_addr(start_addr),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .uinst_valid(uinst_valid), .uinst_data(uinst_data), .uinst_ready(uinst_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [0:4095];
  always @(posedge clk) if (rom_en) rom_dout <= mem[rom_addr];

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] got_iss[$], exp_iss[$];
  int            got_icyc[$], exp_icyc[$];
  logic [AW-1:0] got_f[$], exp_f[$];
  int            got_done_cyc, exp_done_cyc, stab_err, stall_cnt;

  function automatic logic [DW-1:0] mk(input logic [1:0] op, input logic [AW-1:0] tgt, input logic [7:0] cnt);
    logic [DW-1:0] w;
    w = {$urandom, $urandom};
    w[DW-1 -: 2]  = op;
    w[DW-3 -: AW] = tgt;
    w[7:0]        = cnt;
    return w;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) mem[i] = mk(2'b11, '0, 8'd0);
  endtask

  // Program-level model: walks the ROM with the sequencing rules; with ready always high each
  // EXEC costs 3 cycles, JUMP/LOOP 2, and the first issue may be stretched by `hold` cycles.
  task automatic model(input logic [AW-1:0] sa, input int hold);
    logic [AW-1:0] pc;
    logic [DW-1:0] w;
    int f, rem;
    bit first;
    pc = sa; f = 1; rem = -1; first = 1;
    exp_iss.delete(); exp_icyc.delete(); exp_f.delete(); exp_done_cyc = -1;
    for (int s = 0; s < 4000; s++) begin
      exp_f.push_back(pc);
      w = mem[pc];
      if (w[DW-1 -: 2] == 2'b00) begin
        exp_iss.push_back(w); exp_icyc.push_back(f + 2);
        f = f + 3 + (first ? hold : 0); first = 0; pc = pc + 1'b1;
      end else if (w[DW-1 -: 2] == 2'b01) begin
        pc = w[DW-3 -: AW]; f = f + 2;
      end else if (w[DW-1 -: 2] == 2'b10) begin
        if (rem < 0) rem = int'(w[7:0]);
        if (rem > 0) begin rem = rem - 1; pc = w[DW-3 -: AW]; end
        else begin rem = -1; pc = pc + 1'b1; end
        f = f + 2;
      end else begin
        exp_done_cyc = f + 2;
        break;
      end
    end
  endtask

  // mode 0: ready high; 1: random ready; 2: ready low for the first `hold` valid cycles.
  task automatic run_prog(input logic [AW-1:0] sa, input int mode, input int hold, input int xs,
                          input logic [AW-1:0] xa, input bit chain, input logic [AW-1:0] ca,
                          input int budget);
    int t0, rel, holds;
    logic pv, phs;
    logic [DW-1:0] pd;
    bit fin;
    got_iss.delete(); got_icyc.delete(); got_f.delete();
    got_done_cyc = -1; stab_err = 0; stall_cnt = 0;
    holds = hold; pv = 0; phs = 0; pd = '0; fin = 0;
    @(negedge clk);
    start = 1'b1; start_addr = sa; uinst_ready = 1'b1;
    t0 = cyc + 1;
    for (int i = 0; i < budget && !fin; i++) begin
      @(negedge clk);
      rel = cyc - t0 + 1;
      if (rom_en) got_f.push_back(rom_addr);
      if (uinst_valid && !pv) got_icyc.push_back(rel);
      if (pv && !phs && (!uinst_valid || uinst_data !== pd)) stab_err++;
      if (mode == 1) uinst_ready = 1'($urandom_range(0, 1));
      else if (mode == 2 && uinst_valid && holds > 0) begin uinst_ready = 1'b0; holds--; end
      else uinst_ready = 1'b1;
      phs = uinst_valid && uinst_ready;
      if (phs) got_iss.push_back(uinst_data);
      if (uinst_valid && !uinst_ready) stall_cnt++;
      pv = uinst_valid; pd = uinst_data;
      start = (rel == xs);
      if (rel == xs) start_addr = xa;
      if (done) begin
        got_done_cyc = rel; fin = 1;
        start = chain;
        if (chain) start_addr = ca;
      end
    end
    uinst_ready = 1'b1;
    checks++;
    if (!fin) begin errors++; $display("FAIL timeout: done not seen within %0d cycles", budget); end
  endtask

  logic [DW-1:0] wa, wb, wc, wd, we;

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rom_en, uinst_valid, busy, done} !== 4'b0 || rom_addr !== '0 || uinst_data !== '0) begin
      errors++; $display("FAIL reset_values: en/valid/busy/done=%b addr=%h data=%h want all zero",
                         {rom_en, uinst_valid, busy, done}, rom_addr, uinst_data);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rom_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: rom_en=%b busy=%b want 0 0", rom_en, busy);
    end
  endtask

  task automatic load_straight();
    clear_rom();
    wa = mk(2'b00, 12'h0AA, 8'h11); wb = mk(2'b00, 12'h0BB, 8'h22);
    mem[12'h010] = wa; mem[12'h011] = wb; mem[12'h012] = mk(2'b11, '0, 8'd0);
  endtask

  task automatic test_straight();
    load_straight();
    run_prog(12'h010, 0, 0, -1, '0, 0, '0, 200);
    checks++; if (got_iss.size() != 2) begin errors++; $display("FAIL straight_count: got %0d want 2", got_iss.size()); end
    checks++; if (got_iss[0] !== wa) begin errors++; $display("FAIL straight_a: got %h want %h", got_iss[0], wa); end
    checks++; if (got_iss[1] !== wb) begin errors++; $display("FAIL straight_b: got %h want %h", got_iss[1], wb); end
    checks++; if (got_icyc[0] != 3) begin errors++; $display("FAIL straight_a_cycle: got %0d want 3", got_icyc[0]); end
    checks++; if (got_icyc[1] != 6) begin errors++; $display("FAIL straight_b_cycle: got %0d want 6", got_icyc[1]); end
    checks++; if (got_done_cyc != 9) begin errors++; $display("FAIL straight_done_cycle: got %0d want 9", got_done_cyc); end
    checks++; if (got_f.size() != 3) begin errors++; $display("FAIL straight_fetch_count: got %0d want 3", got_f.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_f[i] !== 12'(16 + i)) begin errors++; $display("FAIL straight_fetch%0d: got %h want %h", i, got_f[i], 12'(16 + i)); end
    end
  endtask

  task automatic test_backpressure();
    load_straight();
    model(12'h010, 5);
    run_prog(12'h010, 2, 5, -1, '0, 0, '0, 200);
    checks++; if (stall_cnt != 5) begin errors++; $display("FAIL bp_stall_cycles: got %0d want 5", stall_cnt); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stab_err); end
    checks++; if (got_iss[0] !== wa || got_iss[1] !== wb) begin errors++; $display("FAIL bp_data: got %h %h want %h %h", got_iss[0], got_iss[1], wa, wb); end
    checks++; if (got_icyc[1] != 11) begin errors++; $display("FAIL bp_b_cycle: got %0d want 11", got_icyc[1]); end
    checks++; if (got_done_cyc != exp_done_cyc) begin errors++; $display("FAIL bp_done_cycle: got %0d want %0d", got_done_cyc, exp_done_cyc); end
  endtask

  task automatic test_jump();
    clear_rom();
    wc = mk(2'b00, 12'h0CC, 8'h33);
    mem[0] = mk(2'b01, 12'h100, 8'd0); mem[1] = mk(2'b00, 12'h0EE, 8'h44);
    mem[12'h100] = wc; mem[12'h101] = mk(2'b11, '0, 8'd0);
    run_prog(12'h000, 0, 0, -1, '0, 0, '0, 200);
    checks++; if (got_iss.size() != 1 || got_iss[0] !== wc) begin errors++; $display("FAIL jump_issue: got n=%0d %h want n=1 %h", got_iss.size(), got_iss[0], wc); end
    checks++; if (got_icyc[0] != 5) begin errors++; $display("FAIL jump_cycle: got %0d want 5", got_icyc[0]); end
    checks++;
    if (got_f.size() != 3 || got_f[0] !== 12'h000 || got_f[1] !== 12'h100 || got_f[2] !== 12'h101) begin
      errors++; $display("FAIL jump_fetches: got n=%0d %h %h %h want 000 100 101", got_f.size(), got_f[0], got_f[1], got_f[2]);
    end
  endtask

  task automatic test_loop(input logic [7:0] n);
    clear_rom();
    wd = mk(2'b00, 12'h0DD, 8'h55);
    mem[0] = wd; mem[1] = mk(2'b10, 12'h000, n); mem[2] = mk(2'b11, '0, 8'd0);
    model(12'h000, 0);
    run_prog(12'h000, 0, 0, -1, '0, 0, '0, 400);
    checks++; if (got_iss.size() != int'(n) + 1) begin errors++; $display("FAIL loop%0d_count: got %0d want %0d", n, got_iss.size(), int'(n) + 1); end
    for (int i = 0; i < got_iss.size(); i++) begin
      checks++;
      if (got_iss[i] !== wd) begin errors++; $display("FAIL loop%0d_data%0d: got %h want %h", n, i, got_iss[i], wd); end
    end
    checks++; if (got_done_cyc != exp_done_cyc) begin errors++; $display("FAIL loop%0d_done_cycle: got %0d want %0d", n, got_done_cyc, exp_done_cyc); end
    checks++;
    if (got_icyc.size() != exp_icyc.size() || got_icyc[got_icyc.size()-1] != exp_icyc[exp_icyc.size()-1]) begin
      errors++; $display("FAIL loop%0d_issue_cycles: got n=%0d want n=%0d", n, got_icyc.size(), exp_icyc.size());
    end
  endtask

  task automatic test_start_busy(input int xs);
    load_straight();
    mem[12'h200] = mk(2'b00, 12'h0FF, 8'h66);
    run_prog(12'h010, 0, 0, xs, 12'h200, 0, '0, 200);
    checks++; if (got_iss.size() != 2 || got_iss[0] !== wa || got_iss[1] !== wb) begin errors++; $display("FAIL busy_start%0d_issues: got n=%0d %h want %h %h", xs, got_iss.size(), got_iss[0], wa, wb); end
    checks++; if (got_done_cyc != 9) begin errors++; $display("FAIL busy_start%0d_done: got %0d want 9", xs, got_done_cyc); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rom_en !== 1'b0) begin errors++; $display("FAIL busy_start%0d_idle: busy=%b rom_en=%b want 0 0", xs, busy, rom_en); end
  endtask

  task automatic test_start_on_done();
    bit seen_e, fin;
    load_straight();
    we = mk(2'b00, 12'h0E0, 8'h77);
    mem[12'h300] = we; mem[12'h301] = mk(2'b11, '0, 8'd0);
    run_prog(12'h010, 0, 0, -1, '0, 1, 12'h300, 200);
    @(negedge clk);
    start = 1'b0;
    checks++; if (rom_en !== 1'b1 || rom_addr !== 12'h300) begin errors++; $display("FAIL chain_fetch: rom_en=%b addr=%h want 1 300", rom_en, rom_addr); end
    seen_e = 0; fin = 0;
    for (int i = 0; i < 50 && !fin; i++) begin
      @(negedge clk);
      if (uinst_valid && uinst_data === we) seen_e = 1;
      if (done) fin = 1;
    end
    checks++; if (!seen_e || !fin) begin errors++; $display("FAIL chain_program: issued=%0d done=%0d want 1 1", seen_e, fin); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] ww;
    clear_rom();
    ww = mk(2'b00, 12'h0AB, 8'h88);
    mem[12'hFFF] = ww; mem[12'h000] = mk(2'b11, '0, 8'd0);
    run_prog(12'hFFF, 0, 0, -1, '0, 0, '0, 200);
    checks++; if (got_f.size() != 2 || got_f[0] !== 12'hFFF || got_f[1] !== 12'h000) begin errors++; $display("FAIL wrap_fetches: got n=%0d %h %h want FFF 000", got_f.size(), got_f[0], got_f[1]); end
    checks++; if (got_iss[0] !== ww) begin errors++; $display("FAIL wrap_issue: got %h want %h", got_iss[0], ww); end
  endtask

  task automatic test_random(input int iters);
    logic [AW-1:0] base, base2, a;
    int n1, n2;
    for (int it = 0; it < iters; it++) begin
      clear_rom();
      base = AW'($urandom); base2 = base + 12'd64;
      n1 = $urandom_range(1, 6); n2 = $urandom_range(0, 5);
      a = base;
      for (int k = 0; k < n1; k++) begin mem[a] = mk(2'b00, AW'($urandom), 8'($urandom)); a = a + 1'b1; end
      mem[a] = mk(2'b10, base, 8'($urandom_range(0, 3))); a = a + 1'b1;
      mem[a] = mk(2'b01, base2, 8'($urandom));
      a = base2;
      for (int k = 0; k < n2; k++) begin mem[a] = mk(2'b00, AW'($urandom), 8'($urandom)); a = a + 1'b1; end
      mem[a] = mk(2'b11, '0, 8'd0);
      model(base, 0);
      run_prog(base, 1, 0, -1, '0, 0, '0, 3000);
      checks++; if (got_iss.size() != exp_iss.size()) begin errors++; $display("FAIL rand%0d_issue_count: got %0d want %0d", it, got_iss.size(), exp_iss.size()); end
      for (int i = 0; i < exp_iss.size(); i++) begin
        checks++;
        if (got_iss[i] !== exp_iss[i]) begin errors++; $display("FAIL rand%0d_issue%0d: got %h want %h", it, i, got_iss[i], exp_iss[i]); end
      end
      checks++; if (got_f.size() != exp_f.size()) begin errors++; $display("FAIL rand%0d_fetch_count: got %0d want %0d", it, got_f.size(), exp_f.size()); end
      for (int i = 0; i < exp_f.size(); i++) begin
        checks++;
        if (got_f[i] !== exp_f[i]) begin errors++; $display("FAIL rand%0d_fetch%0d: got %h want %h", it, i, got_f[i], exp_f[i]); end
      end
      checks++; if (stab_err != 0) begin errors++; $display("FAIL rand%0d_stable: got %0d unstable cycles want 0", it, stab_err); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_rom();
    mem[12'h040] = mk(2'b00, 12'h0C0, 8'h99);
    @(negedge clk);
    start = 1'b1; start_addr = 12'h040; uinst_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = uinst_valid; end
    checks++; if (!seen) begin errors++; $display("FAIL rmid_reach_issue: valid=%b want 1", uinst_valid); end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({rom_en, uinst_valid, busy, done} !== 4'b0 || rom_addr !== '0 || uinst_data !== '0) begin
      errors++; $display("FAIL rmid_async: en/valid/busy/done=%b addr=%h data=%h want all zero",
                         {rom_en, uinst_valid, busy, done}, rom_addr, uinst_data);
    end
    @(negedge clk);
    rstn = 1'b1; uinst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rom_en !== 1'b0 || busy !== 1'b0 || uinst_valid !== 1'b0) begin
        errors++; $display("FAIL rmid_idle%0d: rom_en=%b busy=%b valid=%b want 0 0 0", i, rom_en, busy, uinst_valid);
      end
    end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_straight();
    test_backpressure();
    test_jump();
    test_loop(8'd2);
    test_loop(8'd0);
    test_start_busy(4);
    test_start_busy(8);
    test_start_on_done();
    test_wrap();
    test_random(6);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
